// File: rtl/fma16_pkg.sv
// fma16_pkg: shared fp16 types, operation record and result-stage state for the fp16 multiplier scheduler
package fma16_pkg;
    localparam int OP_TAGW = 2;
    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RTZ = 2'd1;
    localparam logic [1:0] RM_RDN = 2'd2;
    localparam logic [1:0] RM_RUP = 2'd3;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    typedef logic [15:0] fp16_t;

    typedef struct packed {
        fp16_t              x;
        fp16_t              y;
        logic               negp;
        logic [1:0]         roundmode;
        logic [OP_TAGW-1:0] tag;
    } op_t;

    typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/fmamul_rr_pick.sv
// fmamul_rr_pick: two-way round-robin grant; on contention the requester other than lg wins
module fmamul_rr_pick (
    input  logic [1:0] req_valid,
    input  logic       lg,
    output logic [1:0] grant
);
    assign grant = {req_valid[1] & (~req_valid[0] | ~lg),
                    req_valid[0] & (~req_valid[1] | lg)};
endmodule

// File: rtl/fmamult.sv
// fmamult: combinational IEEE fp16 multiplier with product negation, four rounding modes and
// flags {invalid, overflow, underflow, inexact}
module fmamult import fma16_pkg::*; (
    input  fp16_t      x,
    input  fp16_t      y,
    input  logic       negp,
    input  logic [1:0] roundmode,
    output fp16_t      p,
    output logic [3:0] flags
);
    logic [4:0]  ea, eb;
    logic [10:0] ma, mb;
    logic [21:0] prod, pn, sh;
    logic [6:0]  e_enc;
    logic [16:0] rnd;
    logic        sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, invalid, nan;
    logic        lost, g, st, inc, inx, ovf, ovf_inf;
    int          k, e, s;

    always_comb begin
        ea = x[14:10];
        eb = y[14:10];
        sign = x[15] ^ y[15] ^ negp;
        a_nan = (ea == 5'd31) & (x[9:0] != 10'd0);
        b_nan = (eb == 5'd31) & (y[9:0] != 10'd0);
        a_inf = (ea == 5'd31) & (x[9:0] == 10'd0);
        b_inf = (eb == 5'd31) & (y[9:0] == 10'd0);
        a_zero = (ea == 5'd0) & (x[9:0] == 10'd0);
        b_zero = (eb == 5'd0) & (y[9:0] == 10'd0);
        invalid = (a_nan & ~x[9]) | (b_nan & ~y[9]) | (a_inf & b_zero) | (b_inf & a_zero);
        nan = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        ma = {|ea, x[9:0]};
        mb = {|eb, y[9:0]};
        prod = 22'(ma) * 22'(mb);
        k = 0;
        for (int i = 0; i < 22; i++)
            if (prod[i]) k = i;
        pn = prod << (21 - k);
        e = k + int'(ea == 5'd0 ? 5'd1 : ea) + int'(eb == 5'd0 ? 5'd1 : eb) - 35;
        // Tiny results are denormalised here so that a rounding carry lands in the exponent naturally
        s = (e < 1) ? ((1 - e) > 22 ? 22 : 1 - e) : 0;
        sh = pn >> s;
        lost = |(pn & ~(22'h3FFFFF << s));
        g = sh[10];
        st = (|sh[9:0]) | lost;
        inx = g | st;
        e_enc = (e < 1) ? 7'd0 : 7'(e);
        inc = (roundmode == RM_RNE) ? g & (st | sh[11]) :
              (roundmode == RM_RTZ) ? 1'b0 :
              (roundmode == RM_RDN) ? sign & inx : ~sign & inx;
        rnd = {e_enc, sh[20:11]} + 17'(inc);
        ovf = rnd[16:10] >= 7'd31;
        ovf_inf = (roundmode == RM_RNE) | ((roundmode == RM_RDN) & sign) | ((roundmode == RM_RUP) & ~sign);
        p = nan ? FP16_QNAN :
            (a_inf | b_inf) ? {sign, 15'h7C00} :
            (a_zero | b_zero) ? {sign, 15'h0000} :
            ovf ? {sign, ovf_inf ? 15'h7C00 : 15'h7BFF} : {sign, rnd[14:0]};
        flags = nan ? {invalid, 3'b000} :
                (a_inf | b_inf | a_zero | b_zero) ? 4'b0000 :
                ovf ? 4'b0101 : {2'b00, ~sh[21] & inx, inx};
    end
endmodule

// File: rtl/fmamul_sched.sv
// fmamul_sched: two requesters share one fp16 multiplier through a round-robin pick and a
// one-entry registered result stage that accepts back-to-back when drained in the same cycle
module fmamul_sched import fma16_pkg::*; #(
    parameter int TAGW = OP_TAGW,
    parameter int CNTW = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0][15:0]     req_x,
    input  logic [1:0][15:0]     req_y,
    input  logic [1:0]           req_negp,
    input  logic [1:0][1:0]      req_roundmode,
    input  logic [1:0][TAGW-1:0] req_tag,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [15:0]          res_product,
    output logic [3:0]           res_flags,
    output logic                 res_id,
    output logic [TAGW-1:0]      res_tag,
    output logic [1:0][CNTW-1:0] acc_cnt
);
    state_t     state, state_nx;
    op_t        op;
    fp16_t      mul_p;
    logic [3:0] mul_flags;
    logic [1:0] grant;
    logic       lg, gid, can_accept, acc;

    fmamul_rr_pick u_pick (
        .req_valid (req_valid),
        .lg        (lg),
        .grant     (grant)
    );

    fmamult u_mul (
        .x         (op.x),
        .y         (op.y),
        .negp      (op.negp),
        .roundmode (op.roundmode),
        .p         (mul_p),
        .flags     (mul_flags)
    );

    always_comb begin
        gid = grant[1];
        op = '{x: req_x[gid], y: req_y[gid], negp: req_negp[gid],
               roundmode: req_roundmode[gid], tag: OP_TAGW'(req_tag[gid])};
        // Reset gates readiness so nothing is accepted while the held result is discarded
        can_accept = reset_n & ((state == EMPTY) | res_ready);
        req_ready = grant & {2{can_accept}};
        acc = |req_ready;
        state_nx = acc ? FULL : (res_ready ? EMPTY : state);
    end

    assign res_valid = (state == FULL);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= EMPTY;
            lg <= 1'b1;
            res_product <= '0;
            res_flags <= '0;
            res_id <= 1'b0;
            res_tag <= '0;
            acc_cnt <= '0;
        end else begin
            state <= state_nx;
            if (acc) begin
                lg <= gid;
                res_product <= mul_p;
                res_flags <= mul_flags;
                res_id <= gid;
                res_tag <= TAGW'(op.tag);
                acc_cnt[gid] <= acc_cnt[gid] + CNTW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fmamul_sched.sv
// tb_fmamul_sched: directed scenario tasks with hand-computed fp16 products and handshake expectations
module tb_fmamul_sched;
    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [1:0][15:0] req_x = '0;
    logic [1:0][15:0] req_y = '0;
    logic [1:0]      req_negp = '0;
    logic [1:0][1:0] req_roundmode = '0;
    logic [1:0][1:0] req_tag = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [15:0]     res_product;
    logic [3:0]      res_flags;
    logic            res_id;
    logic [1:0]      res_tag;
    logic [1:0][7:0] acc_cnt;
    int checks = 0;
    int failures = 0;

    fmamul_sched #(.TAGW(2), .CNTW(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_x         (req_x),
        .req_y         (req_y),
        .req_negp      (req_negp),
        .req_roundmode (req_roundmode),
        .req_tag       (req_tag),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_product   (res_product),
        .res_flags     (res_flags),
        .res_id        (res_id),
        .res_tag       (res_tag),
        .acc_cnt       (acc_cnt)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        req_valid = 2'b11;
        res_ready = 1'b1;
        req_x[0] = 16'h3C00;
        req_y[0] = 16'h4000;
        step;
        step;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b want=00", req_ready); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", res_valid); end
        checks++; if (res_product !== 16'h0000) begin failures++; $display("FAIL reset_product got=%h want=0000", res_product); end
        checks++; if (res_flags !== 4'h0) begin failures++; $display("FAIL reset_flags got=%h want=0", res_flags); end
        checks++; if (res_id !== 1'b0) begin failures++; $display("FAIL reset_id got=%b want=0", res_id); end
        checks++; if (res_tag !== 2'b00) begin failures++; $display("FAIL reset_tag got=%b want=00", res_tag); end
        checks++; if (acc_cnt !== 16'h0000) begin failures++; $display("FAIL reset_cnt got=%h want=0000", acc_cnt); end
        req_valid = 2'b00;
        reset_n = 1'b1;
    endtask

    task automatic test_single;
        req_valid = 2'b01;
        req_x[0] = 16'h3C00;
        req_y[0] = 16'h4000;
        req_tag[0] = 2'b01;
        res_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready got=%b want=01", req_ready); end
        step;
        req_valid = 2'b00;
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b want=1", res_valid); end
        checks++; if (res_product !== 16'h4000) begin failures++; $display("FAIL single_product got=%h want=4000", res_product); end
        checks++; if (res_id !== 1'b0) begin failures++; $display("FAIL single_id got=%b want=0", res_id); end
        checks++; if (res_tag !== 2'b01) begin failures++; $display("FAIL single_tag got=%b want=01", res_tag); end
        checks++; if (res_flags !== 4'h0) begin failures++; $display("FAIL single_flags got=%h want=0", res_flags); end
        checks++; if (acc_cnt[0] !== 8'd1 || acc_cnt[1] !== 8'd0) begin failures++; $display("FAIL single_cnt got=%0d/%0d want=1/0", acc_cnt[0], acc_cnt[1]); end
        step;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b want=0", res_valid); end
    endtask

    task automatic test_round_robin;
        reset_n = 1'b0;
        step;
        reset_n = 1'b1;
        req_valid = 2'b11;
        req_x[0] = 16'h3C00; req_y[0] = 16'h4000; req_tag[0] = 2'b00;
        req_x[1] = 16'h4000; req_y[1] = 16'h4000; req_tag[1] = 2'b10;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin failures++; $display("FAIL rr_ready[%0d] got=%b want=%b", i, req_ready, (i % 2 == 0) ? 2'b01 : 2'b10); end
            step;
            checks++; if (res_id !== 1'(i % 2)) begin failures++; $display("FAIL rr_id[%0d] got=%b want=%0d", i, res_id, i % 2); end
            checks++; if (res_product !== ((i % 2 == 0) ? 16'h4000 : 16'h4400)) begin failures++; $display("FAIL rr_product[%0d] got=%h want=%h", i, res_product, (i % 2 == 0) ? 16'h4000 : 16'h4400); end
            checks++; if (res_tag !== ((i % 2 == 0) ? 2'b00 : 2'b10)) begin failures++; $display("FAIL rr_tag[%0d] got=%b", i, res_tag); end
        end
        req_valid = 2'b00;
        checks++; if (acc_cnt[0] !== 8'd2 || acc_cnt[1] !== 8'd2) begin failures++; $display("FAIL rr_cnt got=%0d/%0d want=2/2", acc_cnt[0], acc_cnt[1]); end
    endtask

    task automatic test_stall;
        res_ready = 1'b1;
        step;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL stall_predrain got=%b want=0", res_valid); end
        req_valid = 2'b10;
        req_x[1] = 16'h4200;
        req_y[1] = 16'h4200;
        req_tag[1] = 2'b11;
        res_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL stall_accept_ready got=%b want=10", req_ready); end
        step;
        req_x[1] = 16'h3C00;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL stall_ready[%0d] got=%b want=00", i, req_ready); end
            checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%b want=1", i, res_valid); end
            checks++; if (res_product !== 16'h4880) begin failures++; $display("FAIL stall_product[%0d] got=%h want=4880", i, res_product); end
            checks++; if (res_tag !== 2'b11 || res_id !== 1'b1) begin failures++; $display("FAIL stall_tag_id[%0d] got=%b/%b want=11/1", i, res_tag, res_id); end
            step;
        end
        checks++; if (acc_cnt[1] !== 8'd3) begin failures++; $display("FAIL stall_cnt got=%0d want=3", acc_cnt[1]); end
        req_valid = 2'b00;
        res_ready = 1'b1;
        step;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL stall_release got=%b want=0", res_valid); end
    endtask

    task automatic test_back_to_back;
        req_valid = 2'b01;
        req_x[0] = 16'h0000;
        req_y[0] = 16'h4500;
        res_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL b2b_ready0 got=%b want=01", req_ready); end
        step;
        checks++; if (res_valid !== 1'b1 || res_product !== 16'h0000) begin failures++; $display("FAIL b2b_zero got=%b/%h want=1/0000", res_valid, res_product); end
        req_x[0] = 16'h3C00;
        req_y[0] = 16'h4000;
        req_negp[0] = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL b2b_ready1 got=%b want=01", req_ready); end
        step;
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL b2b_bubble got=%b want=1", res_valid); end
        checks++; if (res_product !== 16'hC000) begin failures++; $display("FAIL b2b_negp got=%h want=c000", res_product); end
        checks++; if (acc_cnt[0] !== 8'd4) begin failures++; $display("FAIL b2b_cnt got=%0d want=4", acc_cnt[0]); end
        req_valid = 2'b00;
        req_negp[0] = 1'b0;
        step;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b want=0", res_valid); end
    endtask

    task automatic test_reset_full;
        req_valid = 2'b01;
        req_x[0] = 16'h3C00;
        req_y[0] = 16'h4000;
        res_ready = 1'b0;
        step;
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL rstfull_fill got=%b want=1", res_valid); end
        reset_n = 1'b0;
        req_valid = 2'b11;
        res_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rstfull_ready got=%b want=00", req_ready); end
        step;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rstfull_valid got=%b want=0", res_valid); end
        checks++; if (acc_cnt !== 16'h0000) begin failures++; $display("FAIL rstfull_cnt got=%h want=0000", acc_cnt); end
        reset_n = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rstfull_first_grant got=%b want=01", req_ready); end
        step;
        checks++; if (res_valid !== 1'b1 || res_id !== 1'b0) begin failures++; $display("FAIL rstfull_first_id got=%b/%b want=1/0", res_valid, res_id); end
        req_valid = 2'b00;
        step;
    endtask

    task automatic test_wrap;
        reset_n = 1'b0;
        step;
        reset_n = 1'b1;
        req_valid = 2'b01;
        req_x[0] = 16'h3C00;
        req_y[0] = 16'h4000;
        res_ready = 1'b1;
        repeat (255) step;
        checks++; if (acc_cnt[0] !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d want=255", acc_cnt[0]); end
        step;
        checks++; if (acc_cnt[0] !== 8'd0 || acc_cnt[1] !== 8'd0) begin failures++; $display("FAIL wrap_0 got=%0d/%0d want=0/0", acc_cnt[0], acc_cnt[1]); end
        req_valid = 2'b00;
        step;
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_stall;
        test_back_to_back;
        test_reset_full;
        test_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
